// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//
// Registered operand/control stage that feeds the 64-bit ALU. One decoded
// instruction is captured per valid/ready handshake. Both source operands
// are resolved through EX/MEM and MEM/WB forwarding, and operand 2 can be
// replaced by the immediate. The 2-bit ALUOp plus funct fields are turned
// into the 4-bit ALU opcode.
//
// While the held entry is stalled, MEM/WB writes keep refreshing the held
// operands, so a stall never leaves a stale operand behind.
//
// Parameters
//   n                       datapath width
//   r                       register-address width
//
// Ports
//   input_clk               clock, rising edge
//   input_reset             synchronous active-high reset
//   input_valid             upstream offers an instruction
//   output_ready            stage can accept this cycle (combinational)
//   input_flush             kill held entry and any same-cycle capture
//   input_downstream_ready  ALU side consumes the held entry this cycle
//   input_rs1/rs2_addr      source register numbers
//   input_rs1/rs2_data      register-file read data
//   input_immediate         sign-extended immediate
//   input_alu_src           1 = operand 2 is the immediate
//   input_alu_op            ALUOp from main control
//   input_funct3            instruction funct3
//   input_funct7_5          instruction bit 30
//   input_rd_addr           destination register
//   input_exmem_*           EX/MEM forwarding source (regwrite, rd, data)
//   input_memwb_*           MEM/WB forwarding source (regwrite, rd, data)
//   output_valid            held entry is valid
//   output_data_1/2         ALU operands
//   output_store_data       forwarded rs2, always the register value
//   output_opcode           ALU opcode
//   output_rd_addr          destination passed through
//   output_illegal          ALUOp/funct combination not supported
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int n = 64,
  parameter int r = 5
) (
  input  logic         input_clk,
  input  logic         input_reset,
  input  logic         input_valid,
  output logic         output_ready,
  input  logic         input_flush,
  input  logic         input_downstream_ready,
  input  logic [r-1:0] input_rs1_addr,
  input  logic [r-1:0] input_rs2_addr,
  input  logic [n-1:0] input_rs1_data,
  input  logic [n-1:0] input_rs2_data,
  input  logic [n-1:0] input_immediate,
  input  logic         input_alu_src,
  input  logic [1:0]   input_alu_op,
  input  logic [2:0]   input_funct3,
  input  logic         input_funct7_5,
  input  logic [r-1:0] input_rd_addr,
  input  logic         input_exmem_regwrite,
  input  logic         input_memwb_regwrite,
  input  logic [r-1:0] input_exmem_rd,
  input  logic [r-1:0] input_memwb_rd,
  input  logic [n-1:0] input_exmem_data,
  input  logic [n-1:0] input_memwb_data,
  output logic         output_valid,
  output logic [n-1:0] output_data_1,
  output logic [n-1:0] output_data_2,
  output logic [n-1:0] output_store_data,
  output logic [3:0]   output_opcode,
  output logic [r-1:0] output_rd_addr,
  output logic         output_illegal
);

  // ALU opcode encodings
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;

  // ALUOp encodings from main control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  localparam logic [r-1:0] REG_ZERO = {r{1'b0}};

  // Held entry
  logic         valid_r;
  logic [n-1:0] data_1_r;
  logic [n-1:0] data_2_r;
  logic [n-1:0] store_data_r;
  logic [3:0]   opcode_r;
  logic [r-1:0] rd_addr_r;
  logic         illegal_r;
  // Kept only so the stall snoop knows which operands to refresh
  logic [r-1:0] rs1_addr_r;
  logic [r-1:0] rs2_addr_r;
  logic         alu_src_r;

  // Handshake and datapath intermediates
  logic         ready_s;
  logic         accept_s;
  logic         consume_s;
  logic         snoop_s;
  logic [n-1:0] fwd_rs1_s;
  logic [n-1:0] fwd_rs2_s;
  logic [n-1:0] operand_2_s;
  logic [3:0]   opcode_s;
  logic         illegal_s;

  // Resolve one source operand: EX/MEM beats MEM/WB, and x0 is never
  // forwarded because a write to x0 is architecturally discarded.
  function automatic logic [n-1:0] forward_operand(
    input logic [r-1:0] rs,
    input logic [n-1:0] rf_data,
    input logic         exmem_we,
    input logic [r-1:0] exmem_rd,
    input logic [n-1:0] exmem_data,
    input logic         memwb_we,
    input logic [r-1:0] memwb_rd,
    input logic [n-1:0] memwb_data
  );
    logic [n-1:0] result;
    if (exmem_we && (exmem_rd != REG_ZERO) && (exmem_rd == rs)) begin
      result = exmem_data;
    end else if (memwb_we && (memwb_rd != REG_ZERO) && (memwb_rd == rs)) begin
      result = memwb_data;
    end else begin
      result = rf_data;
    end
    return result;
  endfunction

  // Handshake: ready while empty or while the held entry leaves this cycle
  always_comb begin
    ready_s   = (!valid_r) || input_downstream_ready;
    accept_s  = input_valid && ready_s && (!input_flush);
    consume_s = valid_r && input_downstream_ready;
    // Only a stalled entry is refreshed; a departing entry needs no update
    snoop_s   = valid_r && (!input_downstream_ready) &&
                input_memwb_regwrite && (input_memwb_rd != REG_ZERO);
  end

  // Operand forwarding and immediate selection for the incoming instruction
  always_comb begin
    fwd_rs1_s = forward_operand(input_rs1_addr, input_rs1_data,
                                input_exmem_regwrite, input_exmem_rd, input_exmem_data,
                                input_memwb_regwrite, input_memwb_rd, input_memwb_data);
    fwd_rs2_s = forward_operand(input_rs2_addr, input_rs2_data,
                                input_exmem_regwrite, input_exmem_rd, input_exmem_data,
                                input_memwb_regwrite, input_memwb_rd, input_memwb_data);
    if (input_alu_src) begin
      operand_2_s = input_immediate;
    end else begin
      operand_2_s = fwd_rs2_s;
    end
  end

  // ALUOp/funct translation; unsupported R-type combinations fall back to add
  always_comb begin
    opcode_s  = OP_ADD;
    illegal_s = 1'b0;
    case (input_alu_op)
      ALUOP_ADD:  opcode_s = OP_ADD;
      ALUOP_SUB:  opcode_s = OP_SUB;
      ALUOP_PASS: opcode_s = OP_PASS;
      ALUOP_FUNCT: begin
        case ({input_funct3, input_funct7_5})
          4'b000_0: opcode_s = OP_ADD;
          4'b000_1: opcode_s = OP_SUB;
          4'b111_0: opcode_s = OP_AND;
          4'b110_0: opcode_s = OP_OR;
          default: begin
            opcode_s  = OP_ADD;
            illegal_s = 1'b1;
          end
        endcase
      end
      default: begin
        opcode_s  = OP_ADD;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Entry register: reset, flush, capture, retire, or MEM/WB refresh while stalled
  always_ff @(posedge input_clk) begin
    if (input_reset) begin
      valid_r      <= 1'b0;
      data_1_r     <= {n{1'b0}};
      data_2_r     <= {n{1'b0}};
      store_data_r <= {n{1'b0}};
      opcode_r     <= 4'b0000;
      rd_addr_r    <= {r{1'b0}};
      illegal_r    <= 1'b0;
      rs1_addr_r   <= {r{1'b0}};
      rs2_addr_r   <= {r{1'b0}};
      alu_src_r    <= 1'b0;
    end else if (input_flush) begin
      // Data left as-is; it is don't-care while invalid
      valid_r <= 1'b0;
    end else if (accept_s) begin
      // Covers capture into an empty stage and consume+capture replacement
      valid_r      <= 1'b1;
      data_1_r     <= fwd_rs1_s;
      data_2_r     <= operand_2_s;
      store_data_r <= fwd_rs2_s;
      opcode_r     <= opcode_s;
      rd_addr_r    <= input_rd_addr;
      illegal_r    <= illegal_s;
      rs1_addr_r   <= input_rs1_addr;
      rs2_addr_r   <= input_rs2_addr;
      alu_src_r    <= input_alu_src;
    end else if (consume_s) begin
      valid_r <= 1'b0;
    end else if (snoop_s) begin
      if (rs1_addr_r == input_memwb_rd) begin
        data_1_r <= input_memwb_data;
      end else begin
        data_1_r <= data_1_r;
      end
      if (rs2_addr_r == input_memwb_rd) begin
        store_data_r <= input_memwb_data;
        // An immediate operand 2 does not depend on rs2
        if (!alu_src_r) begin
          data_2_r <= input_memwb_data;
        end else begin
          data_2_r <= data_2_r;
        end
      end else begin
        store_data_r <= store_data_r;
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  assign output_ready      = ready_s;
  assign output_valid      = valid_r;
  assign output_data_1     = data_1_r;
  assign output_data_2     = data_2_r;
  assign output_store_data = store_data_r;
  assign output_opcode     = opcode_r;
  assign output_rd_addr    = rd_addr_r;
  assign output_illegal    = illegal_r;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
//
// Self-checking bench for ex_operand_stage. A reference model computes the
// forwarded/decoded entry whenever the bench drives an accepted instruction
// and pushes it to a scoreboard queue; the queue front is what the stage
// must be holding. Each test task makes its own inline comparisons.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic        flush;
  logic        ds_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [63:0] rs1_data, rs2_data, imm;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        exmem_we, memwb_we;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [63:0] exmem_data, memwb_data;
  logic        out_valid;
  logic [63:0] out_d1, out_d2, out_st;
  logic [3:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_ill;

  typedef struct {
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] st;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        src;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ex_operand_stage dut (
    .input_clk              (clk),
    .input_reset            (reset),
    .input_valid            (in_valid),
    .output_ready           (out_ready),
    .input_flush            (flush),
    .input_downstream_ready (ds_ready),
    .input_rs1_addr         (rs1_addr),
    .input_rs2_addr         (rs2_addr),
    .input_rs1_data         (rs1_data),
    .input_rs2_data         (rs2_data),
    .input_immediate        (imm),
    .input_alu_src          (alu_src),
    .input_alu_op           (alu_op),
    .input_funct3           (funct3),
    .input_funct7_5         (funct7_5),
    .input_rd_addr          (rd_addr),
    .input_exmem_regwrite   (exmem_we),
    .input_memwb_regwrite   (memwb_we),
    .input_exmem_rd         (exmem_rd),
    .input_memwb_rd         (memwb_rd),
    .input_exmem_data       (exmem_data),
    .input_memwb_data       (memwb_data),
    .output_valid           (out_valid),
    .output_data_1          (out_d1),
    .output_data_2          (out_d2),
    .output_store_data      (out_st),
    .output_opcode          (out_op),
    .output_rd_addr         (out_rd),
    .output_illegal         (out_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference forwarding rule
  function automatic logic [63:0] m_fwd(input logic [4:0] rs, input logic [63:0] rf);
    if (exmem_we && exmem_rd != 5'd0 && exmem_rd == rs) return exmem_data;
    if (memwb_we && memwb_rd != 5'd0 && memwb_rd == rs) return memwb_data;
    return rf;
  endfunction

  // Reference decode: returns {illegal, opcode}
  function automatic logic [4:0] m_dec(input logic [1:0] aop, input logic [2:0] f3, input logic f7);
    if (aop == 2'b00) return 5'b0_0010;
    if (aop == 2'b01) return 5'b0_0110;
    if (aop == 2'b11) return 5'b0_0111;
    if (f3 == 3'b000 && f7 == 1'b0) return 5'b0_0010;
    if (f3 == 3'b000 && f7 == 1'b1) return 5'b0_0110;
    if (f3 == 3'b111 && f7 == 1'b0) return 5'b0_0000;
    if (f3 == 3'b110 && f7 == 1'b0) return 5'b0_0001;
    return 5'b1_0010;
  endfunction

  // Advance the model by one cycle from the currently driven inputs, then clock
  task automatic tick();
    exp_t       e;
    logic       m_ready, acc, cons;
    logic [4:0] dec;
    m_ready = (q.size() == 0) || ds_ready;
    acc     = in_valid && m_ready && !flush;
    cons    = (q.size() != 0) && ds_ready;
    if (reset || flush) begin
      q.delete();
    end else if (acc) begin
      dec   = m_dec(alu_op, funct3, funct7_5);
      e.d1  = m_fwd(rs1_addr, rs1_data);
      e.st  = m_fwd(rs2_addr, rs2_data);
      e.d2  = alu_src ? imm : e.st;
      e.op  = dec[3:0];
      e.ill = dec[4];
      e.rd  = rd_addr;
      e.rs1 = rs1_addr;
      e.rs2 = rs2_addr;
      e.src = alu_src;
      if (q.size() != 0) void'(q.pop_front());
      q.push_back(e);
    end else if (cons) begin
      void'(q.pop_front());
    end else if (q.size() != 0 && memwb_we && memwb_rd != 5'd0) begin
      e = q[0];
      if (e.rs1 == memwb_rd) e.d1 = memwb_data;
      if (e.rs2 == memwb_rd) begin
        e.st = memwb_data;
        if (!e.src) e.d2 = memwb_data;
      end
      q[0] = e;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; flush = 1'b0; ds_ready = 1'b1;
    rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
    rs1_data = 64'd0; rs2_data = 64'd0; imm = 64'd0;
    alu_src = 1'b0; alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0;
    exmem_we = 1'b0; exmem_rd = 5'd0; exmem_data = 64'd0;
    memwb_we = 1'b0; memwb_rd = 5'd0; memwb_data = 64'd0;
  endtask

  task automatic set_instr(input logic [4:0] a1, input logic [4:0] a2,
                           input logic [63:0] v1, input logic [63:0] v2,
                           input logic [63:0] im, input logic src,
                           input logic [1:0] aop, input logic [2:0] f3,
                           input logic f7, input logic [4:0] rd);
    in_valid = 1'b1;
    rs1_addr = a1; rs2_addr = a2; rs1_data = v1; rs2_data = v2;
    imm = im; alu_src = src; alu_op = aop; funct3 = f3; funct7_5 = f7;
    rd_addr = rd;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (out_op !== 4'b0000) begin
      n_fail++; $display("FAIL reset_opcode: got %b expected 0000", out_op);
    end
    n_checks++;
    if ({out_d1, out_d2, out_st, out_rd, out_ill} !== 198'd0) begin
      n_fail++; $display("FAIL reset_data: d1 %h d2 %h st %h rd %0d ill %b expected all 0",
                         out_d1, out_d2, out_st, out_rd, out_ill);
    end
    reset = 1'b0;
    ds_ready = 1'b0;
    #1;
    n_checks++;
    if (out_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", out_ready);
    end
    ds_ready = 1'b1;
  endtask

  task automatic test_ex_forward();
    clear_inputs();
    set_instr(5'd3, 5'd4, 64'd11, 64'd40, 64'd0, 1'b0, 2'b10, 3'b000, 1'b1, 5'd9);
    exmem_we = 1'b1; exmem_rd = 5'd3; exmem_data = 64'd100;
    tick();
    clear_inputs();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL exfwd_valid: got %b expected 1", out_valid);
    end
    n_checks++;
    if ({out_d1, out_d2, out_op} !== {64'd100, 64'd40, 4'b0110}) begin
      n_fail++; $display("FAIL exfwd_values: d1 %0d d2 %0d op %b expected 100 40 0110",
                         out_d1, out_d2, out_op);
    end
    n_checks++;
    if (q.size() == 0) begin
      n_fail++; $display("FAIL exfwd_sb: scoreboard empty, expected one entry");
    end else if ({out_st, out_rd, out_ill} !== {q[0].st, q[0].rd, q[0].ill}) begin
      n_fail++; $display("FAIL exfwd_sb: st %0d rd %0d ill %b expected %0d %0d %b",
                         out_st, out_rd, out_ill, q[0].st, q[0].rd, q[0].ill);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL exfwd_consume: got valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    // Both stages target x5: EX/MEM wins
    set_instr(5'd5, 5'd5, 64'd1, 64'd2, 64'd0, 1'b0, 2'b00, 3'b000, 1'b0, 5'd1);
    exmem_we = 1'b1; exmem_rd = 5'd5; exmem_data = 64'd7;
    memwb_we = 1'b1; memwb_rd = 5'd5; memwb_data = 64'd9;
    tick();
    n_checks++;
    if ({out_d1, out_d2, out_st} !== {64'd7, 64'd7, 64'd7}) begin
      n_fail++; $display("FAIL fwd_priority: d1 %0d d2 %0d st %0d expected 7 7 7",
                         out_d1, out_d2, out_st);
    end
    // Both stages target x0: regfile value is used
    set_instr(5'd0, 5'd0, 64'h55, 64'h66, 64'd0, 1'b0, 2'b00, 3'b000, 1'b0, 5'd2);
    exmem_rd = 5'd0; exmem_data = 64'd123;
    memwb_rd = 5'd0; memwb_data = 64'd456;
    tick();
    n_checks++;
    if ({out_d1, out_d2} !== {64'h55, 64'h66}) begin
      n_fail++; $display("FAIL fwd_x0: d1 %h d2 %h expected 55 66", out_d1, out_d2);
    end
    // Only MEM/WB matches rs1; EX/MEM matches rs2 only
    set_instr(5'd8, 5'd9, 64'h1, 64'h2, 64'd0, 1'b0, 2'b01, 3'b000, 1'b0, 5'd3);
    exmem_rd = 5'd9; exmem_data = 64'hAB;
    memwb_rd = 5'd8; memwb_data = 64'h77;
    tick();
    clear_inputs();
    n_checks++;
    if (q.size() == 0) begin
      n_fail++; $display("FAIL fwd_memwb: scoreboard empty, expected one entry");
    end else if ({out_d1, out_d2, out_op} !== {q[0].d1, q[0].d2, q[0].op} ||
                 out_d1 !== 64'h77) begin
      n_fail++; $display("FAIL fwd_memwb: d1 %h d2 %h op %b expected %h %h %b",
                         out_d1, out_d2, out_op, q[0].d1, q[0].d2, q[0].op);
    end
    tick();
  endtask

  task automatic test_stall_snoop();
    clear_inputs();
    set_instr(5'd2, 5'd6, 64'h20, 64'h1111, 64'h999, 1'b0, 2'b00, 3'b000, 1'b0, 5'd7);
    ds_ready = 1'b0;
    tick();
    // A different instruction is offered but must not be taken while stalled
    set_instr(5'd9, 5'd9, 64'h3, 64'h4, 64'h5, 1'b0, 2'b01, 3'b000, 1'b0, 5'd10);
    memwb_we = 1'b1; memwb_rd = 5'd6; memwb_data = 64'hDEAD;
    #1;
    n_checks++;
    if (out_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_ready: got %b expected 0", out_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_ready, out_d1, out_d2, out_st, out_rd} !==
        {1'b1, 1'b0, 64'h20, 64'hDEAD, 64'hDEAD, 5'd7}) begin
      n_fail++; $display("FAIL stall_snoop: v %b rdy %b d1 %h d2 %h st %h rd %0d expected 1 0 20 dead dead 7",
                         out_valid, out_ready, out_d1, out_d2, out_st, out_rd);
    end
    // EX/MEM is not snooped while holding
    in_valid = 1'b0;
    memwb_we = 1'b0;
    exmem_we = 1'b1; exmem_rd = 5'd6; exmem_data = 64'hBEEF;
    tick();
    n_checks++;
    if ({out_d2, out_st} !== {64'hDEAD, 64'hDEAD}) begin
      n_fail++; $display("FAIL stall_no_exmem: d2 %h st %h expected dead dead", out_d2, out_st);
    end
    // Snoop and consume together: the entry leaves
    exmem_we = 1'b0;
    memwb_we = 1'b1; memwb_rd = 5'd6; memwb_data = 64'h5555;
    ds_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_consume: got valid %b expected 0", out_valid);
    end
    // Immediate operand keeps the immediate; rs1 match refreshes operand 1
    clear_inputs();
    set_instr(5'd6, 5'd6, 64'h10, 64'h2222, 64'h123, 1'b1, 2'b11, 3'b000, 1'b0, 5'd8);
    ds_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    memwb_we = 1'b1; memwb_rd = 5'd6; memwb_data = 64'hDEAD;
    tick();
    n_checks++;
    if (q.size() == 0) begin
      n_fail++; $display("FAIL stall_imm: scoreboard empty, expected one entry");
    end else if ({out_d1, out_d2, out_st, out_op} !== {q[0].d1, q[0].d2, q[0].st, q[0].op} ||
                 out_d2 !== 64'h123 || out_st !== 64'hDEAD) begin
      n_fail++; $display("FAIL stall_imm: d1 %h d2 %h st %h op %b expected %h %h %h %b",
                         out_d1, out_d2, out_st, out_op, q[0].d1, q[0].d2, q[0].st, q[0].op);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    int valid_cycles;
    clear_inputs();
    valid_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      set_instr(5'(i + 1), 5'(i + 10), 64'(100 + i), 64'(200 + i), 64'(300 + i),
                1'(i % 2), 2'(i), 3'b000, 1'b0, 5'(i + 20));
      tick();
      if (out_valid === 1'b1) valid_cycles++;
      n_checks++;
      if (q.size() == 0) begin
        n_fail++; $display("FAIL b2b_entry%0d: scoreboard empty", i);
      end else if ({out_valid, out_d1, out_d2, out_st, out_op, out_rd} !==
                   {1'b1, q[0].d1, q[0].d2, q[0].st, q[0].op, q[0].rd}) begin
        n_fail++; $display("FAIL b2b_entry%0d: v %b d1 %0d d2 %0d st %0d op %b rd %0d expected 1 %0d %0d %0d %b %0d",
                           i, out_valid, out_d1, out_d2, out_st, out_op, out_rd,
                           q[0].d1, q[0].d2, q[0].st, q[0].op, q[0].rd);
      end
    end
    n_checks++;
    if (valid_cycles != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d valid cycles expected 4", valid_cycles);
    end
    // Flush together with a valid offer: nothing is held next cycle
    set_instr(5'd1, 5'd2, 64'd1, 64'd2, 64'd0, 1'b0, 2'b00, 3'b000, 1'b0, 5'd3);
    flush = 1'b1;
    tick();
    clear_inputs();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] aops [5] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b10};
    logic [2:0] f3s  [5] = '{3'b100, 3'b100, 3'b111, 3'b110, 3'b111};
    logic       f7s  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0] exps [5] = '{5'b1_0010, 5'b0_0111, 5'b0_0000, 5'b0_0001, 5'b1_0010};
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      set_instr(5'd1, 5'd2, 64'd5, 64'd6, 64'd0, 1'b0, aops[i], f3s[i], f7s[i], 5'd4);
      tick();
      n_checks++;
      if ({out_ill, out_op} !== exps[i]) begin
        n_fail++; $display("FAIL decode%0d: ill/op %b expected %b", i, {out_ill, out_op}, exps[i]);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    set_instr(5'd3, 5'd4, 64'hAA, 64'hBB, 64'd0, 1'b0, 2'b01, 3'b000, 1'b0, 5'd6);
    ds_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    n_checks++;
    if ({out_valid, out_d1, out_op, out_rd} !== {1'b0, 64'd0, 4'd0, 5'd0}) begin
      n_fail++; $display("FAIL reset_mid: v %b d1 %h op %b rd %0d expected 0 0 0000 0",
                         out_valid, out_d1, out_op, out_rd);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_ex_forward();
    test_fwd_priority();
    test_stall_snoop();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
